// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU arbiter slice.
// ALU op codes, requester id type, issue tag layout and
// perf-counter width with its saturating increment helper.
package alu_pkg;

    // ALU op-select codes (3-bit encoding of the ALU sig_alu_op input)
    localparam logic [2:0] ALU_Add     = 3'd0;
    localparam logic [2:0] ALU_Sub     = 3'd1;
    localparam logic [2:0] ALU_And     = 3'd2;
    localparam logic [2:0] ALU_SLL     = 3'd3;
    localparam logic [2:0] ALU_SLR     = 3'd4;
    localparam logic [2:0] ALU_OP_IDLE = 3'd7;

    // Two requesters -> a one-bit requester id
    localparam int REQ_ID_W = 1;
    localparam int NUM_REQ  = 2;

    // Performance counter width
    localparam int PERF_W = 16;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    // Record of the request issued to the ALU on the previous edge
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } issue_tag_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// Grants are combinational from req and the priority pointer; the
// pointer moves to the other requester after every grant. All grants
// are suppressed while reset is high.
module rr_arbiter2
    import alu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // Requester that wins when both are asking
    logic prio_q;
    logic prio_d;

    // Grant selection: a lone requester always wins, a tie goes to prio
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer update: after granting requester i, favour 1-i next
    always_comb begin
        prio_d = prio_q;
        if (advance && (gnt != 2'b00)) begin
            prio_d = gnt[0];
        end
    end

    // Pointer register
    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between the execute stage (requester 0)
// and the address/branch-compare unit (requester 1).
// The winner's operands drive the ALU combinationally; a one-entry
// tag records who was issued so the ALU result, which appears one
// cycle later, is flagged back to the right requester.
// Optional build macro ALU_ARB_PERF_EN adds perf_clr and the
// saturating grant0_cnt / grant1_cnt / stall_cnt counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [1:0]       rsp_valid,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_negative,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_negative
`ifdef ALU_ARB_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [PERF_W-1:0] grant0_cnt,
    output logic [PERF_W-1:0] grant1_cnt,
    output logic [PERF_W-1:0] stall_cnt
`endif
);

    logic [1:0] gnt;
    logic [1:0] handshake;
    issue_tag_t tag_q;
    issue_tag_t tag_d;

    assign req_ready = gnt;
    assign handshake = req_valid & req_ready;

    rr_arbiter2 u_rr (
        .clock   (clock),
        .reset   (reset),
        .req     (req_valid),
        .advance (|handshake),
        .gnt     (gnt)
    );

    // Operand mux: winner's fields to the ALU, idle op and zeros otherwise
    always_comb begin
        alu_op = OPW'(ALU_OP_IDLE);
        alu_a  = '0;
        alu_b  = '0;
        if (gnt[0]) begin
            alu_op = req0_op;
            alu_a  = req0_a;
            alu_b  = req0_b;
        end else if (gnt[1]) begin
            alu_op = req1_op;
            alu_a  = req1_a;
            alu_b  = req1_b;
        end
    end

    // Next issue tag: who (if anyone) completes a handshake this edge
    always_comb begin
        tag_d       = '0;
        tag_d.valid = |handshake;
        tag_d.id    = req_id_t'(handshake[1]);
    end

    // Issue tag register; the ALU result lines up with it one cycle later
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    // Response steering: a response in flight while reset is high is dropped
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = tag_q.valid & ~reset & (tag_q.id == req_id_t'(gi));
        end
    endgenerate

    // Result and flags are shared and passed straight through from the ALU
    assign rsp_result   = alu_out;
    assign rsp_zero     = alu_zero;
    assign rsp_negative = alu_negative;

`ifdef ALU_ARB_PERF_EN
    logic              any_stall;
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] stall_cnt_d;

    // A stall cycle is any cycle where some requester asks but is not granted
    assign any_stall = |(req_valid & ~req_ready);

    // Per-requester grant counters
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gcnt
            logic [PERF_W-1:0] cnt_q;
            logic [PERF_W-1:0] cnt_d;

            // Clear wins over increment; increment saturates
            always_comb begin
                cnt_d = cnt_q;
                if (perf_clr) begin
                    cnt_d = '0;
                end else if (handshake[gi]) begin
                    cnt_d = sat_inc(cnt_q);
                end
            end

            // Grant counter register
            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // Stall counter next value: clear wins over increment
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
        end else if (any_stall) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    // Stall counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant0_cnt = g_gcnt[0].cnt_q;
    assign grant1_cnt = g_gcnt[1].cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter.
// A behavioural registered ALU closes the loop. Directed cycles push
// the hand-computed response into a scoreboard; an independent monitor
// pops and compares whenever a response is due.
module tb_alu_arbiter;

    localparam int W = 32;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_SLL  = 3'd3;
    localparam logic [2:0] OP_SLR  = 3'd4;
    localparam logic [2:0] OP_UNDF = 3'd5;
    localparam logic [2:0] OP_IDLE = 3'd7;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [2:0]   req0_op = 3'd0;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic [2:0]   req1_op = 3'd0;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic [1:0]   rsp_valid;
    logic [W-1:0] rsp_result;
    logic         rsp_zero;
    logic         rsp_negative;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_out = '0;
    logic         alu_zero = 1'b0;
    logic         alu_negative = 1'b0;
`ifdef ALU_ARB_PERF_EN
    logic         perf_clr = 1'b0;
    logic [15:0]  grant0_cnt;
    logic [15:0]  grant1_cnt;
    logic [15:0]  stall_cnt;
`endif

    typedef struct {
        logic [1:0]   vld;
        logic [W-1:0] res;
        logic         z;
        logic         n;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    alu_arbiter #(.WIDTH(W), .OPW(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req0_op      (req0_op),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_op      (req1_op),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .rsp_valid    (rsp_valid),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_negative (rsp_negative),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_clr     (perf_clr),
        .grant0_cnt   (grant0_cnt),
        .grant1_cnt   (grant1_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural registered ALU (environment, not the checker)
    function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a << b[4:0];
            3'd4:    return a >> b[4:0];
            default: return '0;
        endcase
    endfunction

    always @(posedge clock) begin
        logic [W-1:0] r;
        r = alu_f(alu_op, alu_a, alu_b);
        alu_out      <= r;
        alu_zero     <= (r == '0);
        alu_negative <= r[W-1];
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare a due response, otherwise demand silence
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            checks++;
            fails++;
            $display("FAIL rsp_missed: got nothing expected rsp_valid %b due cycle %0d", e.vld, e.due);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rsp_valid", W'(rsp_valid), W'(e.vld));
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_zero", W'(rsp_zero), W'(e.z));
            chk("rsp_negative", W'(rsp_negative), W'(e.n));
            $display("rsp  cyc=%0d valid=%b result=%h z=%b n=%b", cyc, rsp_valid, rsp_result, rsp_zero, rsp_negative);
        end else begin
            chk("rsp_idle", W'(rsp_valid), W'(2'b00));
        end
    end

    // One cycle: drive inputs after the edge, check grant and ALU drive mid-cycle
    task automatic cyc_step(input logic [1:0] v,
                            input logic [2:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                            input logic [2:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                            input logic [1:0] exp_rdy, input logic [W-1:0] exp_res,
                            input logic exp_z, input logic exp_n, input bit push, input string name);
        exp_t e;
        @(posedge clock);
        #1;
        req_valid = v;
        req0_op = op0; req0_a = a0; req0_b = b0;
        req1_op = op1; req1_a = a1; req1_b = b1;
        @(negedge clock);
        chk({name, "_ready"}, W'(req_ready), W'(exp_rdy));
        if (exp_rdy == 2'b01) begin
            chk({name, "_alu_op"}, W'(alu_op), W'(op0));
            chk({name, "_alu_a"}, alu_a, a0);
            chk({name, "_alu_b"}, alu_b, b0);
        end else if (exp_rdy == 2'b10) begin
            chk({name, "_alu_op"}, W'(alu_op), W'(op1));
            chk({name, "_alu_a"}, alu_a, a1);
            chk({name, "_alu_b"}, alu_b, b1);
        end else begin
            chk({name, "_alu_op"}, W'(alu_op), W'(OP_IDLE));
            chk({name, "_alu_a"}, alu_a, '0);
            chk({name, "_alu_b"}, alu_b, '0);
        end
        $display("req  %s cyc=%0d valid=%b ready=%b op=%0d a=%h b=%h", name, cyc, v, req_ready, alu_op, alu_a, alu_b);
        if (push && exp_rdy != 2'b00) begin
            e.vld = exp_rdy; e.res = exp_res; e.z = exp_z; e.n = exp_n; e.due = cyc + 1;
            sb.push_back(e);
        end
    endtask

    initial begin
        // Reset state, with both requesters asking to prove grants are gated
        reset = 1'b1;
        req_valid = 2'b11;
        req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd1;
        req1_op = OP_SUB; req1_a = 32'd1; req1_b = 32'd1;
        repeat (2) @(negedge clock);
        chk("rst_ready", W'(req_ready), W'(2'b00));
        chk("rst_rsp_valid", W'(rsp_valid), W'(2'b00));
        chk("rst_alu_op", W'(alu_op), W'(OP_IDLE));
        chk("rst_alu_a", alu_a, '0);
        chk("rst_alu_b", alu_b, '0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        req_valid = 2'b00;

        // Single requester 0: Add 5+7
        cyc_step(2'b01, OP_ADD, 32'd5, 32'd7, OP_IDLE, '0, '0, 2'b01, 32'd12, 1'b0, 1'b0, 1'b1, "add");
        // Single requester 1 (prio currently 1): Sub 2-5
        cyc_step(2'b10, OP_IDLE, '0, '0, OP_SUB, 32'd2, 32'd5, 2'b10, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b1, "sub_neg");
        // Both valid: alternate 01,10,01
        cyc_step(2'b11, OP_SUB, 32'd3, 32'd3, OP_SLL, 32'd1, 32'd4, 2'b01, 32'd0, 1'b1, 1'b0, 1'b1, "dbl0");
        cyc_step(2'b11, OP_SUB, 32'd3, 32'd3, OP_SLL, 32'd1, 32'd4, 2'b10, 32'd16, 1'b0, 1'b0, 1'b1, "dbl1");
        cyc_step(2'b11, OP_SUB, 32'd3, 32'd3, OP_SLL, 32'd1, 32'd4, 2'b01, 32'd0, 1'b1, 1'b0, 1'b1, "dbl2");
        // Idle cycles
        for (int k = 0; k < 3; k++)
            cyc_step(2'b00, OP_ADD, 32'd9, 32'd9, OP_ADD, 32'd9, 32'd9, 2'b00, '0, 1'b0, 1'b0, 1'b0, "idle");

        // Grant, then reset in the response cycle: response must be dropped
        cyc_step(2'b01, OP_ADD, 32'd2, 32'd2, OP_IDLE, '0, '0, 2'b01, 32'd4, 1'b0, 1'b0, 1'b0, "pre_rst");
        @(posedge clock);
        #1;
        reset = 1'b1;
        req_valid = 2'b00;
        @(negedge clock);
        chk("rst_drop_rsp_valid", W'(rsp_valid), W'(2'b00));
        chk("rst_drop_ready", W'(req_ready), W'(2'b00));
        @(posedge clock);
        #1;
        reset = 1'b0;
        // prio back to 0: double request grants req0
        cyc_step(2'b11, OP_ADD, 32'd1, 32'd2, OP_AND, 32'd3, 32'd3, 2'b01, 32'd3, 1'b0, 1'b0, 1'b1, "post_rst");

        // Undefined op passes through and yields 0 with zero set
        cyc_step(2'b01, OP_UNDF, 32'd9, 32'd9, OP_IDLE, '0, '0, 2'b01, 32'd0, 1'b1, 1'b0, 1'b1, "undef_op");
        // Requester 1 logical shift right
        cyc_step(2'b10, OP_IDLE, '0, '0, OP_SLR, 32'h8000_0000, 32'd4, 2'b10, 32'h0800_0000, 1'b0, 1'b0, 1'b1, "slr");
        // Requester handover: 0 drops while 1 raises, no bubble
        cyc_step(2'b01, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, OP_IDLE, '0, '0, 2'b01, 32'hF000_F000, 1'b0, 1'b1, 1'b1, "hand0");
        cyc_step(2'b10, OP_IDLE, '0, '0, OP_ADD, 32'd10, 32'd20, 2'b10, 32'd30, 1'b0, 1'b0, 1'b1, "hand1");
        cyc_step(2'b00, OP_IDLE, '0, '0, OP_IDLE, '0, '0, 2'b00, '0, 1'b0, 1'b0, 1'b0, "idle");

`ifdef ALU_ARB_PERF_EN
        // Clear, then 10 cycles of both valid
        perf_clr = 1'b1;
        @(posedge clock);
        #1;
        perf_clr = 1'b0;
        @(negedge clock);
        chk("perf_clr_g0", W'(grant0_cnt), '0);
        chk("perf_clr_g1", W'(grant1_cnt), '0);
        chk("perf_clr_st", W'(stall_cnt), '0);
        for (int k = 0; k < 10; k++)
            cyc_step(2'b11, OP_ADD, 32'd1, 32'd1, OP_AND, 32'd6, 32'd3,
                     (k % 2 == 0) ? 2'b01 : 2'b10, 32'd2, 1'b0, 1'b0, 1'b1, "perf_dbl");
        cyc_step(2'b00, OP_IDLE, '0, '0, OP_IDLE, '0, '0, 2'b00, '0, 1'b0, 1'b0, 1'b0, "idle");
        chk("perf_g0", W'(grant0_cnt), 32'd5);
        chk("perf_g1", W'(grant1_cnt), 32'd5);
        chk("perf_st", W'(stall_cnt), 32'd10);
        perf_clr = 1'b1;
        @(posedge clock);
        #1;
        perf_clr = 1'b0;
        @(negedge clock);
        chk("perf_clr2_g0", W'(grant0_cnt), '0);
        chk("perf_clr2_g1", W'(grant1_cnt), '0);
        chk("perf_clr2_st", W'(stall_cnt), '0);
`endif

        repeat (3) cyc_step(2'b00, OP_IDLE, '0, '0, OP_IDLE, '0, '0, 2'b00, '0, 1'b0, 1'b0, 1'b0, "tail");
        chk("scoreboard_drained", W'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single registered ALU of the processor between two requesters: requester 0 is the execute stage, requester 1 is the address/branch-compare unit. Arbitration is round-robin with a valid/ready handshake on each request port. The block drives the ALU operand and op inputs for the granted request and routes the ALU result and flags back to the winning requester with a one-cycle response. It sits between the decode/execute control logic and the ALU instance.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- OPW, 3, ALU op-select width.

Ports (clock is `clock`; reset is `reset`, one clock domain, reset synchronous and active-high):
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid[1:0]  in  2  request valid, one bit per requester
- req_ready[1:0]  out  2  grant: the request is issued this cycle
- req0_op, req1_op  in  OPW  ALU op
- req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands
- rsp_valid[1:0]  out  2  response valid, one-hot or zero
- rsp_result  out  WIDTH  result, shared by both requesters
- rsp_zero, rsp_negative  out  1  flags, shared
- alu_op  out  OPW  to ALU sig_alu_op
- alu_a, alu_b  out  WIDTH  to ALU A, B
- alu_out  in  WIDTH  from ALU Output
- alu_zero, alu_negative  in  1  from ALU flags

## Operation
- Round-robin pointer `prio` has reset value 0.
- Only one requester valid: that requester is granted.
- Both valid: requester `prio` is granted.
- After any grant to requester i, `prio` becomes 1-i. `prio` does not change on a cycle with no grant.
- At most one bit of req_ready is high. req_ready is combinational from req_valid and `prio`. A handshake is req_valid[i] & req_ready[i].
- Requesters hold op, a and b stable while valid and not ready. The block does not check this.
- Granted cycle: alu_op, alu_a and alu_b are the winner's fields, combinationally.
- Idle cycle: alu_op = ALU_OP_IDLE (3'd7, the ALU default, which produces 0), and alu_a = alu_b = 0.
- Issue tracking: the registered `tag_valid` and `tag_id` capture the handshake at each rising edge.
- Response: rsp_valid[tag_id] = tag_valid. rsp_result, rsp_zero and rsp_negative pass alu_out and the ALU flags through.
- There is no response backpressure. Requesters must accept the response in the cycle it is presented.
- Op codes pass through unchanged. An undefined op gives result 0 with zero=1; this is not an error.

## Timing
- Reset values:
  - req_ready = 00 during reset, because grants are gated by reset.
  - rsp_valid = 00 and `prio` = 0.
  - alu_op = ALU_OP_IDLE, alu_a = alu_b = 0.
  - rsp_result and flags are don't-care while rsp_valid = 00.
- Latency: a handshake at edge N gives rsp_valid high in cycle N+1 with the matching result.
- Throughput: one issue per cycle. Both requesters held valid alternate grants 0,1,0,1… when `prio` = 0 at start.
- Reset asserted in the cycle after a grant: that response is dropped, and rsp_valid = 00 in the next cycle.
- A requester dropping req_valid in the same cycle the other raises it: the other requester is granted; no bubble.

## Configuration
- Macro `ALU_ARB_PERF_EN`.
- When defined, the block adds:
  - input perf_clr (1 bit)
  - outputs grant0_cnt, grant1_cnt, stall_cnt (16 bits each, saturating at 16'hFFFF)
- Counter behaviour:
  - grantN_cnt increments on each handshake of requester N.
  - stall_cnt increments on each cycle in which any req_valid bit is high without its req_ready.
  - Reset or perf_clr clears all counters on the next edge; perf_clr has priority over increment.
- When the macro is undefined, these ports and registers do not exist and the block behaviour is otherwise identical.

## Structure
- Package `alu_pkg`:
  - op constants ALU_Add = 3'd0, ALU_Sub = 3'd1, ALU_And = 3'd2, ALU_SLL = 3'd3, ALU_SLR = 3'd4, ALU_OP_IDLE = 3'd7
  - REQ_ID width constant (1)
  - perf counter width (16)
- One sub-module `rr_arbiter2`:
  - inputs: clock, reset, req[1:0], advance
  - output: one-hot gnt[1:0]
  - holds `prio`
- Operand muxing, tag pipeline and perf counters live in `alu_arbiter`.

## Test plan
- After reset, req_valid = 01 with Add 5+7: req_ready = 01; next cycle rsp_valid = 01, rsp_result = 12, zero = 0, negative = 0.
- Both requesters valid continuously, req0 Sub 3-3, req1 SLL 1<<4:
  - grants alternate 01,10,01.
  - responses alternate: result 0 with zero = 1, then result 16.
- req1 valid alone with Sub 2-5: granted immediately; response 32'hFFFFFFFD, negative = 1. A following double request grants req0 first.
- Reset asserted the cycle after a grant: rsp_valid stays 00. After reset, `prio` = 0 and a double request grants req0.
- No requests: alu_op = 7, alu_a = alu_b = 0, rsp_valid = 00 in every cycle.
- With ALU_ARB_PERF_EN and 10 cycles of both requesters valid: grant0_cnt = 5, grant1_cnt = 5, stall_cnt = 10. perf_clr then reads 0 on the next cycle.
